regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (Reg_Write / W_Addr / W_Data) between two write-back requesters: req0 = ALU/EX and req1 = MEM/load.
- Round-robin grant with valid/ready handshakes and a registered write port.
- Holds a 32-entry pending-write scoreboard so decode can detect RAW hazards on both read ports.
- Sits between the pipeline write-back stages and the register file.

Parameters:
- NREG, 32, number of architectural registers (scoreboard depth).
- AW, 5, register address width (log2 NREG).
- DW, 32, data width.

Ports:
- clk_Regs  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid  in  1  ALU write-back request
- req0_addr  in  AW  ALU destination register
- req0_data  in  DW  ALU result
- req0_ready  out  1  ALU request accepted this cycle
- req1_valid  in  1  MEM write-back request
- req1_addr  in  AW  load destination register
- req1_data  in  DW  load data
- req1_ready  out  1  MEM request accepted this cycle
- rsv_valid  in  1  decode reserves a destination register
- rsv_addr  in  AW  register to mark pending
- R_Addr_A  in  AW  read port A address being decoded
- R_Addr_B  in  AW  read port B address being decoded
- busy_A  out  1  R_Addr_A has a pending write
- busy_B  out  1  R_Addr_B has a pending write
- Reg_Write  out  1  register-file write enable (registered)
- W_Addr  out  AW  register-file write address (registered)
- W_Data  out  DW  register-file write data (registered)

Behaviour:
- Reset (rst_n=0 at a clock edge): Reg_Write=0, W_Addr=0, W_Data=0, busy vector=0, rr_prio=0. req0_ready, req1_ready, busy_A and busy_B are forced to 0 while rst_n=0.
- Grant logic is combinational from reqN_valid and rr_prio. reqN_ready is the grant. A valid request must never depend on ready.
- Only one request valid: it is granted.
- Both valid: the requester selected by rr_prio is granted. rr_prio then flips to the other requester at the edge.
- No contention: rr_prio is unchanged.
- A loser holds valid, addr and data stable until it is granted.
- Transfer = valid & ready.
- On transfer at edge N, the port outputs are driven starting cycle N+1:
  - Reg_Write=1, W_Addr=addr, W_Data=data, for exactly one cycle unless a new transfer occurs.
  - Latency is 1 cycle. Throughput is one write per cycle.
- No transfer: Reg_Write=0 next cycle. W_Addr and W_Data hold their last values.
- addr=0 (x0): the request is accepted (ready=1) but Reg_Write stays 0. It still consumes the grant and advances rr_prio if contended.
- Scoreboard busy[NREG-1:0]:
  - Set: at an edge with rsv_valid=1 and rsv_addr!=0, busy[rsv_addr] is set.
  - Clear: at an edge with Reg_Write=1, busy[W_Addr] is cleared. This is the same edge on which the register file commits, so a cleared bit guarantees the data is readable.
  - Same register set and cleared on the same edge: set wins (the newer producer is pending).
  - busy[0] is constantly 0.
- busy_A = busy[R_Addr_A], busy_B = busy[R_Addr_B]. Combinational reads with no bypass of same-cycle reserve or clear.
- Reset mid-operation: any granted-but-not-yet-driven write is dropped (Reg_Write=0 after reset) and all pending bits are cleared. The pipeline is flushed together with this block.
- Addresses are AW wide, so no out-of-range address exists. Widths are not extended.

Decomposition:
- Shared package (regfile_pkg):
  - AW, DW, NREG constants.
  - Requester index constants REQ_ALU=0, REQ_MEM=1.
  - The write-request record type (valid, addr, data).
- Sub-module rr_arb2: 2-way round-robin arbiter with valid in, grant out and a priority flop.
- The scoreboard stays inline in regfile_wb_arbiter.

Test Plan:
- Single request: reset, then req0 valid addr=5 data=0xDEAD_BEEF for 1 cycle -> req0_ready=1 that cycle; next cycle Reg_Write=1, W_Addr=5, W_Data=0xDEADBEEF; the cycle after, Reg_Write=0.
- Contention: both valid every cycle for 4 cycles (req0 addr=1..4, req1 addr=9..12, each requester advancing only when granted) -> grants alternate req0, req1, req0, req1; writes seen are 1, 9, 2, 10.
- x0 write: req1 addr=0 data=0x1234 -> req1_ready=1; Reg_Write stays 0 the following cycle.
- Scoreboard path: rsv_valid addr=7, then R_Addr_A=7 -> busy_A=1. Then req0 addr=7 -> busy_A stays 1 during the Reg_Write cycle and becomes 0 after that edge.
- Set-over-clear: Reg_Write to addr 3 while rsv_valid addr=3 on the same edge -> busy[3] remains 1. Reserving addr 0 -> busy_B stays 0 for R_Addr_B=0.
- Reset mid-operation: grant req0 addr=6 with reg 6 reserved, then assert rst_n=0 on the next edge -> Reg_Write=0, busy vector=0, readies=0 while in reset; rr_prio back to req0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    // x0 is hard-wired zero: never written, never pending
    function automatic logic is_x0(input logic [AW-1:0] addr);
        return (addr == {AW{1'b0}});
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; priority only moves when both requesters contend.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    logic prio_q;
    logic prio_d;

    // Grant selection and priority update; no grants while in reset
    always_comb begin
        grant_o = 2'b00;
        prio_d  = prio_q;
        if (!rst_n) begin
            grant_o = 2'b00;
        end else begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11: begin
                    grant_o = prio_q ? 2'b10 : 2'b01;
                    prio_d  = ~prio_q;
                end
                default: grant_o = 2'b00;
            endcase
        end
    end

    // Priority flop, starts at the ALU requester
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and MEM write-back and
// tracks pending destination registers for RAW hazard detection.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic          clk_Regs,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_addr,
    input  logic [AW-1:0] R_Addr_A,
    input  logic [AW-1:0] R_Addr_B,
    output logic          busy_A,
    output logic          busy_B,
    output logic          Reg_Write,
    output logic [AW-1:0] W_Addr,
    output logic [DW-1:0] W_Data
);

    wb_req_t   req0_s;
    wb_req_t   req1_s;
    wb_req_t   sel_s;
    logic [1:0] grant_s;

    logic          reg_write_q, reg_write_d;
    logic [AW-1:0] w_addr_q,    w_addr_d;
    logic [DW-1:0] w_data_q,    w_data_d;
    logic [NREG-1:0] busy_q,    busy_d;

    assign req0_s = '{valid: req0_valid, addr: req0_addr, data: req0_data};
    assign req1_s = '{valid: req1_valid, addr: req1_addr, data: req1_data};

    rr_arb2 u_arb (
        .clk     (clk_Regs),
        .rst_n   (rst_n),
        .valid_i ({req1_valid, req0_valid}),
        .grant_o (grant_s)
    );

    assign req0_ready = grant_s[REQ_ALU];
    assign req1_ready = grant_s[REQ_MEM];

    // Select the granted request and form the next write-port values
    always_comb begin
        sel_s       = '0;
        reg_write_d = 1'b0;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        if (grant_s[REQ_MEM]) begin
            sel_s = req1_s;
        end else if (grant_s[REQ_ALU]) begin
            sel_s = req0_s;
        end else begin
            sel_s = '0;
        end
        if (sel_s.valid) begin
            reg_write_d = !is_x0(sel_s.addr);
            w_addr_d    = sel_s.addr;
            w_data_d    = sel_s.data;
        end else begin
            reg_write_d = 1'b0;
        end
    end

    // Pending-write vector: clear on commit, then set on reserve so a newer producer wins
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[w_addr_q] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (rsv_valid && !is_x0(rsv_addr)) begin
            busy_d[rsv_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Registered write port and scoreboard state
    always_ff @(posedge clk_Regs) begin
        if (!rst_n) begin
            reg_write_q <= 1'b0;
            w_addr_q    <= {AW{1'b0}};
            w_data_q    <= {DW{1'b0}};
            busy_q      <= {NREG{1'b0}};
        end else begin
            reg_write_q <= reg_write_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            busy_q      <= busy_d;
        end
    end

    assign Reg_Write = reg_write_q;
    assign W_Addr    = w_addr_q;
    assign W_Data    = w_data_q;
    assign busy_A    = rst_n & busy_q[R_Addr_A];
    assign busy_B    = rst_n & busy_q[R_Addr_B];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write-port scoreboard queue.
module tb_regfile_wb_arbiter;

    logic        clk_Regs = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsv_valid;
    logic [4:0]  req0_addr, req1_addr, rsv_addr, R_Addr_A, R_Addr_B;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, busy_A, busy_B, Reg_Write;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    logic exp_prio;
    int   i0, i1;

    regfile_wb_arbiter dut (
        .clk_Regs   (clk_Regs),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .R_Addr_A   (R_Addr_A),
        .R_Addr_B   (R_Addr_B),
        .busy_A     (busy_A),
        .busy_B     (busy_B),
        .Reg_Write  (Reg_Write),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data)
    );

    always #5 clk_Regs = ~clk_Regs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample after the edge and retire any observed write
    task automatic tick();
        exp_t e;
        @(posedge clk_Regs);
        #1;
        if (Reg_Write === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, W_Addr}, 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("w_addr", {59'd0, W_Addr}, {59'd0, e.addr});
                chk("w_data", {32'd0, W_Data}, {32'd0, e.data});
            end
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'd0;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'd0;
        rsv_valid = 1'b0; rsv_addr = 5'd0; R_Addr_A = 5'd0; R_Addr_B = 5'd0;
        tick();
        tick();
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
        chk("rst_reg_write", {63'd0, Reg_Write}, 64'd0);
        chk("rst_w_addr", {59'd0, W_Addr}, 64'd0);
        chk("rst_w_data", {32'd0, W_Data}, 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        exp_prio = 1'b0;

        // Single ALU request
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
        #1;
        chk("single_ready0", {63'd0, req0_ready}, 64'd1);
        chk("single_ready1", {63'd0, req1_ready}, 64'd0);
        push(5'd5, 32'hDEAD_BEEF);
        tick();
        req0_valid = 1'b0;
        chk("single_we", {63'd0, Reg_Write}, 64'd1);
        tick();
        chk("single_we_drop", {63'd0, Reg_Write}, 64'd0);
        chk("single_addr_hold", {59'd0, W_Addr}, 64'd5);

        // Contention: each side advances only when granted
        i0 = 0; i1 = 0;
        for (int c = 0; c < 4; c++) begin
            req0_valid = 1'b1; req0_addr = 5'(1 + i0); req0_data = 32'h1000_0000 + 32'(i0);
            req1_valid = 1'b1; req1_addr = 5'(9 + i1); req1_data = 32'h2000_0000 + 32'(i1);
            #1;
            chk("cont_ready0", {63'd0, req0_ready}, {63'd0, (exp_prio == 1'b0)});
            chk("cont_ready1", {63'd0, req1_ready}, {63'd0, (exp_prio == 1'b1)});
            if (exp_prio == 1'b0) begin
                push(req0_addr, req0_data);
                i0++;
            end else begin
                push(req1_addr, req1_data);
                i1++;
            end
            exp_prio = ~exp_prio;
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("cont_drained", 64'(exp_q.size()), 64'd0);

        // x0 write is accepted but never committed
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
        #1;
        chk("x0_ready1", {63'd0, req1_ready}, 64'd1);
        tick();
        req1_valid = 1'b0;
        chk("x0_no_write", {63'd0, Reg_Write}, 64'd0);

        // Scoreboard reserve then clear on commit
        rsv_valid = 1'b1; rsv_addr = 5'd7; R_Addr_A = 5'd7;
        #1;
        chk("sb_no_bypass", {63'd0, busy_A}, 64'd0);
        tick();
        rsv_valid = 1'b0;
        chk("sb_set", {63'd0, busy_A}, 64'd1);
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0077;
        push(5'd7, 32'h0000_0077);
        tick();
        req0_valid = 1'b0;
        chk("sb_busy_during_write", {63'd0, busy_A}, 64'd1);
        chk("sb_write_7", {63'd0, Reg_Write}, 64'd1);
        tick();
        chk("sb_cleared", {63'd0, busy_A}, 64'd0);

        // Set wins over clear on the same edge
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0333;
        push(5'd3, 32'h0000_0333);
        tick();
        req0_valid = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 5'd3; R_Addr_B = 5'd3;
        chk("soc_write_3", {63'd0, Reg_Write}, 64'd1);
        tick();
        rsv_valid = 1'b0;
        chk("soc_busy3", {63'd0, busy_B}, 64'd1);
        rsv_valid = 1'b1; rsv_addr = 5'd0; R_Addr_B = 5'd0;
        tick();
        rsv_valid = 1'b0;
        chk("x0_never_busy", {63'd0, busy_B}, 64'd0);

        // Reset mid-operation with priority moved to MEM
        rsv_valid = 1'b1; rsv_addr = 5'd6; R_Addr_A = 5'd6;
        tick();
        rsv_valid = 1'b0;
        chk("rm_reserved", {63'd0, busy_A}, 64'd1);
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h0000_0666;
        req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h0000_0888;
        #1;
        chk("rm_grant0", {63'd0, req0_ready}, 64'd1);
        push(5'd6, 32'h0000_0666);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rm_ready0_in_rst", {63'd0, req0_ready}, 64'd0);
        chk("rm_ready1_in_rst", {63'd0, req1_ready}, 64'd0);
        chk("rm_busy_in_rst", {63'd0, busy_A}, 64'd0);
        tick();
        chk("rm_reg_write", {63'd0, Reg_Write}, 64'd0);
        chk("rm_w_addr", {59'd0, W_Addr}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rm_busy_cleared", {63'd0, busy_A}, 64'd0);
        chk("rm_prio_alu", {63'd0, req0_ready}, 64'd1);
        chk("rm_prio_mem", {63'd0, req1_ready}, 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
